alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
Result buffer directly downstream of the 8-bit logic units (and/or/xor/not) in the ALU.
- Each cycle it captures the unit's `op` result when `in_valid` is high, tagged with the operation select.
- At capture time it computes zero and parity flags.
- It holds up to DEPTH entries and presents them to the consumer under a valid/ready handshake.
- The logic units cannot stall, so writes that cannot be accepted are dropped and counted.

Parameters:
- WIDTH, 8, result/operand width in bits.
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  `op`/`op_sel` are valid this cycle.
- op  input  WIDTH  result from the logic unit.
- op_sel  input  2  operation tag: 00 and, 01 or, 10 xor, 11 not.
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_op  output  WIDTH  head result.
- out_sel  output  2  head operation tag.
- out_zero  output  1  head result == 0.
- out_parity  output  1  XOR-reduction of head result (1 = odd number of ones).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  log2(DEPTH)+1  entries currently held.
- drop_cnt  output  CNT_W  number of dropped writes, saturating.

Behaviour:
- Reset: the asynchronous reset is active-high, uses a single clock, and takes effect immediately, including mid-operation.
  - Pointers, count and drop_cnt are cleared.
  - out_valid=0, empty=1, full=0.
  - out_op, out_sel, out_zero and out_parity are 0.
  - Stored entry contents are don't-care.
- Read and write conditions:
  - rd = out_valid && out_ready.
  - wr = in_valid && (!full || rd). A write to a full FIFO is accepted when a read happens in the same cycle.
  - drop = in_valid && !wr. drop_cnt increments on drop and holds at 2^CNT_W-1.
- Entry contents: each entry stores {op_sel, parity, zero, op}. Flags are computed from `op` at write time, not at read.
- Latency: data written at edge N is visible on out_* and out_valid from edge N onward (the cycle after it was presented). There is no combinational input-to-output path.
- out_valid = !empty.
  - When empty, out_op/out_sel/out_zero/out_parity are forced to 0; they are masked, never stale.
- Pointers:
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is updated +1 on wr-only, -1 on rd-only, and unchanged on wr&&rd or neither.
- Boundary cases:
  - Empty + in_valid: write only. No read is possible because out_valid=0.
  - Full + in_valid + out_ready: read and write in the same cycle; count stays DEPTH and full stays 1.
  - Full + in_valid + !out_ready: drop; contents unchanged.
  - out_ready while empty: no effect; count never underflows.
- Output stability: a head entry held under out_valid && !out_ready remains stable until it is read.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH default (8).
  - 2-bit opcode localparams OP_AND/OP_OR/OP_XOR/OP_NOT.
  - The entry-layout widths.
- One sub-module is natural: alu_flag_gen (combinational; takes `op` and produces zero and parity), also reusable by the arithmetic path.
- Storage and pointer logic stay inline in alu_result_fifo.

Test Plan:
- Reset then idle → out_valid=0, empty=1, count=0, drop_cnt=0, out_op=0x00; asserting rst mid-stream returns all outputs to these values immediately, without waiting for clk.
- Write op=0x00, op_sel=00 (and of 0x01 & 0x16), then op=0x02, op_sel=00 (and of 0x07 & 0x0A), with out_ready=0 → count=2; head shows out_op=0x00, out_zero=1, out_parity=0.
- Continuing that case, pulse out_ready for one cycle → head becomes out_op=0x02, out_zero=0, out_parity=1, count=1.
- Write 6 back-to-back entries 0x11..0x16 with out_ready=0, DEPTH=4 → full=1, count=4, drop_cnt=2; draining yields 0x11, 0x12, 0x13, 0x14 in order, then empty=1.
- Full FIFO with in_valid=1 and out_ready=1 held for 8 cycles → count stays 4, drop_cnt unchanged, outputs follow FIFO order across pointer wrap-around.
- Use CNT_W=2 and force 5 drops → drop_cnt saturates at 3.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg : shared ALU widths, opcode tags and result-entry layout    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alu_pkg;

   localparam int ALU_WIDTH = 8;
   localparam int SEL_W     = 2;
   localparam int FLAG_W    = 2;

   localparam logic [SEL_W-1:0] OP_AND = 2'b00;
   localparam logic [SEL_W-1:0] OP_OR  = 2'b01;
   localparam logic [SEL_W-1:0] OP_XOR = 2'b10;
   localparam logic [SEL_W-1:0] OP_NOT = 2'b11;

   // Entry is packed as {sel, parity, zero, op}
   function automatic int entry_w(input int width);
      return width + FLAG_W + SEL_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_flag_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_flag_gen : zero and odd-parity flags of a result word          |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] op_i,
   output logic             zero_o,
   output logic             parity_o
);

   assign zero_o   = (op_i == '0);
   assign parity_o = ^op_i;

endmodule
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_result_fifo : flagged result buffer behind the ALU logic units |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         op,
   input  logic [1:0]               op_sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_op,
   output logic [1:0]               out_sel,
   output logic                     out_zero,
   output logic                     out_parity,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = entry_w(WIDTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [EW-1:0]    mem_q [DEPTH];

   logic          w_rd, w_wr, w_drop;
   logic          w_zero, w_parity;
   logic [EW-1:0] w_entry, w_head;

   alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
      .op_i     (op),
      .zero_o   (w_zero),
      .parity_o (w_parity)
   );

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign out_valid = !empty;

   // A full FIFO still accepts a write when the head leaves in the same cycle
   assign w_rd   = out_valid && out_ready;
   assign w_wr   = in_valid && (!full || w_rd);
   assign w_drop = in_valid && !w_wr;

   assign w_entry = {op_sel, w_parity, w_zero, op};

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      drop_cnt_d = drop_cnt_q;
      if (w_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_wr, w_rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (w_drop && (drop_cnt_q != {CNT_W{1'b1}}))
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage needs no reset: every visible field is masked while empty
   always_ff @(posedge clk) begin
      if (w_wr) mem_q[wr_ptr_q] <= w_entry;
   end

   assign w_head     = mem_q[rd_ptr_q];
   assign out_op     = w_head[WIDTH-1:0] & {WIDTH{out_valid}};
   assign out_zero   = w_head[WIDTH] & out_valid;
   assign out_parity = w_head[WIDTH+1] & out_valid;
   assign out_sel    = w_head[EW-1 -: SEL_W] & {SEL_W{out_valid}};

   assign count    = count_q;
   assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_result_fifo : vector table, corner sequences, random + model|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_alu_result_fifo;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] op = '0;
   logic [1:0] op_sel = '0;
   logic       out_ready = 1'b0;

   logic       out_valid, out_zero, out_parity, full, empty;
   logic [7:0] out_op;
   logic [1:0] out_sel;
   logic [2:0] count;
   logic [7:0] drop_cnt;

   logic       s_out_valid, s_out_zero, s_out_parity, s_full, s_empty;
   logic [7:0] s_out_op;
   logic [1:0] s_out_sel;
   logic [2:0] s_count;
   logic [1:0] s_drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_result_fifo #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .op_sel(op_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_sel(out_sel), .out_zero(out_zero), .out_parity(out_parity),
      .full(full), .empty(empty), .count(count), .drop_cnt(drop_cnt)
   );

   // Same stimulus into a narrow drop counter to exercise saturation
   alu_result_fifo #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .op_sel(op_sel),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_op(s_out_op),
      .out_sel(s_out_sel), .out_zero(s_out_zero), .out_parity(s_out_parity),
      .full(s_full), .empty(s_empty), .count(s_count), .drop_cnt(s_drop_cnt)
   );

   typedef struct {
      logic [7:0] op;
      logic [1:0] sel;
   } ent_t;

   ent_t q[$];
   int   drops = 0;

   typedef struct {
      bit         iv;
      logic [7:0] op;
      logic [1:0] sel;
      bit         rdy;
      int         cnt;
      logic [7:0] hop;
      bit         z;
      bit         p;
      int         drp;
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input bit iv, input logic [7:0] o, input logic [1:0] s, input bit rdy);
      bit rd, wr;
      @(negedge clk);
      in_valid  = iv;
      op        = o;
      op_sel    = s;
      out_ready = rdy;
      rd = (q.size() > 0) && rdy;
      wr = iv && ((q.size() < DEPTH) || rd);
      @(posedge clk);
      if (rd) void'(q.pop_front());
      if (wr) q.push_back('{o, s});
      if (iv && !wr) drops++;
      #1;
   endtask

   task automatic check_model(input string tag);
      bit         v;
      logic [7:0] hop;
      logic [1:0] hsel;
      v    = (q.size() > 0);
      hop  = v ? q[0].op : 8'h00;
      hsel = v ? q[0].sel : 2'b00;
      chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
      chk({tag, " empty"}, 32'(empty), 32'(!v));
      chk({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, " count"}, 32'(count), 32'(q.size()));
      chk({tag, " out_op"}, 32'(out_op), 32'(hop));
      chk({tag, " out_sel"}, 32'(out_sel), 32'(hsel));
      chk({tag, " out_zero"}, 32'(out_zero), 32'(v && (hop == 0)));
      chk({tag, " out_parity"}, 32'(out_parity), 32'(v && (^hop)));
      chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'((drops > 255) ? 255 : drops));
      chk({tag, " sat drop_cnt"}, 32'(s_drop_cnt), 32'((drops > 3) ? 3 : drops));
      chk({tag, " sat out_op"}, 32'(s_out_op), 32'(hop));
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      drops = 0;
      check_model(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0]  = '{1, 8'h01 & 8'h16, 2'd0, 0, 1, 8'h00, 1, 0, 0};
      vt[1]  = '{1, 8'h07 & 8'h0A, 2'd0, 0, 2, 8'h00, 1, 0, 0};
      vt[2]  = '{0, 8'h00, 2'd0, 1, 1, 8'h02, 0, 1, 0};
      vt[3]  = '{0, 8'h00, 2'd0, 1, 0, 8'h00, 0, 0, 0};
      vt[4]  = '{1, 8'h11, 2'd0, 0, 1, 8'h11, 0, 0, 0};
      vt[5]  = '{1, 8'h12, 2'd0, 0, 2, 8'h11, 0, 0, 0};
      vt[6]  = '{1, 8'h13, 2'd0, 0, 3, 8'h11, 0, 0, 0};
      vt[7]  = '{1, 8'h14, 2'd0, 0, 4, 8'h11, 0, 0, 0};
      vt[8]  = '{1, 8'h15, 2'd0, 0, 4, 8'h11, 0, 0, 1};
      vt[9]  = '{1, 8'h16, 2'd0, 0, 4, 8'h11, 0, 0, 2};
      vt[10] = '{0, 8'h00, 2'd0, 1, 3, 8'h12, 0, 0, 2};
      vt[11] = '{0, 8'h00, 2'd0, 1, 2, 8'h13, 0, 1, 2};
      vt[12] = '{0, 8'h00, 2'd0, 1, 1, 8'h14, 0, 0, 2};
      vt[13] = '{0, 8'h00, 2'd0, 1, 0, 8'h00, 0, 0, 2};
      vt[14] = '{0, 8'h00, 2'd0, 1, 0, 8'h00, 0, 0, 2};

      // Reset and idle
      #1;
      check_model("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      apply(0, 8'h00, 2'd0, 0);
      check_model("idle");

      // Directed vector table
      for (int i = 0; i < 15; i++) begin
         apply(vt[i].iv, vt[i].op, vt[i].sel, vt[i].rdy);
         chk($sformatf("vec%0d count", i), 32'(count), 32'(vt[i].cnt));
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].cnt != 0));
         chk($sformatf("vec%0d full", i), 32'(full), 32'(vt[i].cnt == DEPTH));
         chk($sformatf("vec%0d out_op", i), 32'(out_op), 32'(vt[i].hop));
         chk($sformatf("vec%0d out_zero", i), 32'(out_zero), 32'(vt[i].z));
         chk($sformatf("vec%0d out_parity", i), 32'(out_parity), 32'(vt[i].p));
         chk($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(vt[i].drp));
      end

      // Full with simultaneous read and write across pointer wrap
      for (int i = 0; i < DEPTH; i++) begin
         apply(1, 8'hA0 + 8'(i), 2'(i), 0);
         check_model($sformatf("fill%0d", i));
      end
      for (int i = 0; i < 8; i++) begin
         apply(1, 8'hB0 + 8'(i), 2'(3 - (i % 4)), 1);
         check_model($sformatf("rw%0d", i));
         chk($sformatf("rw%0d count", i), 32'(count), 32'(DEPTH));
         chk($sformatf("rw%0d head", i), 32'(out_op),
             32'((i < 3) ? (8'hA1 + 8'(i)) : (8'hB0 + 8'(i - 3))));
      end

      // Asynchronous reset while full
      async_reset("midreset");

      // Drop-counter saturation on the narrow instance
      for (int i = 0; i < DEPTH; i++) apply(1, 8'(8'h40 + i), 2'd1, 0);
      for (int i = 0; i < 5; i++) begin
         apply(1, 8'hEE, 2'd2, 0);
         check_model($sformatf("drop%0d", i));
      end
      chk("sat drop_cnt final", 32'(s_drop_cnt), 32'd3);
      chk("wide drop_cnt final", 32'(drop_cnt), 32'd5);

      // Randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         apply(bit'($urandom_range(0, 99) < 60), 8'($urandom), 2'($urandom),
               bit'($urandom_range(0, 99) < 50));
         check_model($sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
